// File: rtl/core_run_monitor.sv
// Run-status monitor: watches register-file writeback and fetch PC, latches PASS/timeout/hang verdict.
// Optional x0 write guard enabled by defining MON_X0_GUARD_EN.
module core_run_monitor #(
  parameter int              XLEN           = 64,
  parameter int              REG_AW         = 5,
  parameter int              SIG_REG        = 31,
  parameter logic [XLEN-1:0] SIG_VALUE      = XLEN'(64'h0000_0000_0000_0ACE),
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter int              HANG_CYCLES    = 64,
  parameter int              CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   pc,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  wb_cnt
`ifdef MON_X0_GUARD_EN
  ,
  output logic              x0_viol
`endif
);

  localparam int HANG_W = (HANG_CYCLES > 2) ? $clog2(HANG_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // Hang fires when the counter is about to step onto HANG_CYCLES-1.
  localparam logic [HANG_W-1:0] HANG_LAST    = HANG_W'(HANG_CYCLES - 2);
  localparam logic [REG_AW-1:0] SIG_ADDR     = REG_AW'(SIG_REG);
  localparam bit                SIG_LIVE     = (SIG_REG != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PASS_S = 2'd2,
    FAIL_S = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        fail_code_reg, fail_code_next;
  logic [CNT_W-1:0]  cycle_cnt_reg, cycle_cnt_next;
  logic [CNT_W-1:0]  wb_cnt_reg, wb_cnt_next;
  logic [HANG_W-1:0] hang_cnt_reg, hang_cnt_next;
  logic [XLEN-1:0]   last_pc_reg, last_pc_next;
`ifdef MON_X0_GUARD_EN
  logic              x0_viol_reg, x0_viol_next;
`endif

  logic pass_hit, timeout_hit, hang_hit, pc_same, wb_qual;

  assign pc_same     = (pc == last_pc_reg);
  assign wb_qual     = wb_we && (wb_addr != '0);
  assign pass_hit    = SIG_LIVE && wb_we && (wb_addr == SIG_ADDR) && (wb_data == SIG_VALUE);
  assign timeout_hit = (cycle_cnt_reg == TIMEOUT_LAST);
  assign hang_hit    = pc_same && (hang_cnt_reg == HANG_LAST);

  always_comb begin
    state_next     = state_reg;
    fail_code_next = fail_code_reg;
    cycle_cnt_next = cycle_cnt_reg;
    wb_cnt_next    = wb_cnt_reg;
    hang_cnt_next  = hang_cnt_reg;
    last_pc_next   = last_pc_reg;
`ifdef MON_X0_GUARD_EN
    x0_viol_next   = x0_viol_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = RUN;
          cycle_cnt_next = '0;
          wb_cnt_next    = '0;
          hang_cnt_next  = '0;
          last_pc_next   = pc;
        end
      end
      RUN: begin
        if (cycle_cnt_reg != '1) cycle_cnt_next = cycle_cnt_reg + 1'b1;
        if (wb_qual && (wb_cnt_reg != '1)) wb_cnt_next = wb_cnt_reg + 1'b1;
        if (pc_same) begin
          hang_cnt_next = hang_cnt_reg + 1'b1;
        end else begin
          hang_cnt_next = '0;
          last_pc_next  = pc;
        end
`ifdef MON_X0_GUARD_EN
        if (wb_we && (wb_addr == '0) && (wb_data != '0)) x0_viol_next = 1'b1;
`endif
        // Signature beats both fail causes when they coincide.
        if (pass_hit) begin
          state_next = PASS_S;
        end else if (timeout_hit) begin
          state_next     = FAIL_S;
          fail_code_next = 2'd1;
        end else if (hang_hit) begin
          state_next     = FAIL_S;
          fail_code_next = 2'd2;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      fail_code_reg <= '0;
      cycle_cnt_reg <= '0;
      wb_cnt_reg    <= '0;
      hang_cnt_reg  <= '0;
      last_pc_reg   <= '0;
`ifdef MON_X0_GUARD_EN
      x0_viol_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      fail_code_reg <= fail_code_next;
      cycle_cnt_reg <= cycle_cnt_next;
      wb_cnt_reg    <= wb_cnt_next;
      hang_cnt_reg  <= hang_cnt_next;
      last_pc_reg   <= last_pc_next;
`ifdef MON_X0_GUARD_EN
      x0_viol_reg   <= x0_viol_next;
`endif
    end
  end

  assign done      = (state_reg == PASS_S) || (state_reg == FAIL_S);
  assign pass      = (state_reg == PASS_S);
  assign fail_code = fail_code_reg;
  assign cycle_cnt = cycle_cnt_reg;
  assign wb_cnt    = wb_cnt_reg;
`ifdef MON_X0_GUARD_EN
  assign x0_viol   = x0_viol_reg;
`endif

endmodule

// File: tb/tb_core_run_monitor.sv
// Directed bench for core_run_monitor (TIMEOUT_CYCLES=50, HANG_CYCLES=8).
// RUN cycles are counted from 0: the first edge seen in RUN is cycle 0.
module tb_core_run_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [63:0] pc;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [31:0] cycle_cnt;
  logic [31:0] wb_cnt;
`ifdef MON_X0_GUARD_EN
  logic        x0_viol;
`endif

  int total = 0;
  int bad   = 0;

  core_run_monitor #(
    .TIMEOUT_CYCLES(50),
    .HANG_CYCLES   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .pc       (pc),
    .done     (done),
    .pass     (pass),
    .fail_code(fail_code),
    .cycle_cnt(cycle_cnt),
    .wb_cnt   (wb_cnt)
`ifdef MON_X0_GUARD_EN
    ,
    .x0_viol  (x0_viol)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n RUN cycles with PC advancing by 4 and no writeback.
  task automatic run_plain(input int n);
    for (int i = 0; i < n; i++) begin
      pc = pc + 64'd4;
      cyc();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; pc = 64'h1000;
    #1;

    // ---------------- basic pass ----------------
    do_reset(3);
    check("rst_done",  64'(done), 64'd0);
    check("rst_pass",  64'(pass), 64'd0);
    check("rst_fc",    64'(fail_code), 64'd0);
    check("rst_cyc",   64'(cycle_cnt), 64'd0);
    check("rst_wb",    64'(wb_cnt), 64'd0);
    do_start();
    check("start_cyc", 64'(cycle_cnt), 64'd0);
    // Cycle 0..9; cycle 2 is a zero write to x0 (bubble), not counted.
    run_plain(2);
    pc = pc + 64'd4; wb_we = 1'b1; wb_addr = 5'd0; wb_data = '0;
    cyc();
    wb_we = 1'b0;
    run_plain(7);
    check("pre_sig_done", 64'(done), 64'd0);
    check("pre_sig_cyc",  64'(cycle_cnt), 64'd10);
    check("pre_sig_wb",   64'(wb_cnt), 64'd0);
    // Cycle 10: signature write.
    pc = pc + 64'd4; wb_we = 1'b1; wb_addr = 5'd31; wb_data = 64'hACE;
    cyc();
    wb_we = 1'b0;
    check("pass_done", 64'(done), 64'd1);
    check("pass_pass", 64'(pass), 64'd1);
    check("pass_fc",   64'(fail_code), 64'd0);
    check("pass_cyc",  64'(cycle_cnt), 64'd11);
    check("pass_wb",   64'(wb_cnt), 64'd1);
    // Terminal: writes, PC motion and a start pulse change nothing.
    for (int i = 0; i < 20; i++) begin
      pc = pc + 64'd4; start = (i == 5); wb_we = 1'b1; wb_addr = 5'd3; wb_data = 64'(i);
      cyc();
    end
    start = 1'b0; wb_we = 1'b0;
    check("hold_done", 64'(done), 64'd1);
    check("hold_pass", 64'(pass), 64'd1);
    check("hold_fc",   64'(fail_code), 64'd0);
    check("hold_cyc",  64'(cycle_cnt), 64'd11);
    check("hold_wb",   64'(wb_cnt), 64'd1);

    // ---------------- timeout ----------------
    do_reset(2);
    check("rst2_done", 64'(done), 64'd0);
    check("rst2_pass", 64'(pass), 64'd0);
    check("rst2_cyc",  64'(cycle_cnt), 64'd0);
    check("rst2_wb",   64'(wb_cnt), 64'd0);
    do_start();
    // Cycles 0..2 write x5 (counted); start pulse at cycle 20 must not restart.
    for (int i = 0; i < 3; i++) begin
      pc = pc + 64'd4; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 64'(i + 1);
      cyc();
    end
    wb_we = 1'b0;
    run_plain(17);
    start = 1'b1; pc = pc + 64'd4;
    cyc();
    start = 1'b0;
    run_plain(28);
    check("to_pre_done", 64'(done), 64'd0);
    check("to_pre_cyc",  64'(cycle_cnt), 64'd49);
    run_plain(1);
    check("to_done", 64'(done), 64'd1);
    check("to_pass", 64'(pass), 64'd0);
    check("to_fc",   64'(fail_code), 64'd1);
    check("to_cyc",  64'(cycle_cnt), 64'd50);
    check("to_wb",   64'(wb_cnt), 64'd3);
    run_plain(5);
    check("to_hold_fc",  64'(fail_code), 64'd1);
    check("to_hold_cyc", 64'(cycle_cnt), 64'd50);

    // ---------------- same-cycle priority ----------------
    do_reset(1);
    do_start();
    run_plain(49);
    pc = pc + 64'd4; wb_we = 1'b1; wb_addr = 5'd31; wb_data = 64'hACE;
    cyc();
    wb_we = 1'b0;
    check("pri_done", 64'(done), 64'd1);
    check("pri_pass", 64'(pass), 64'd1);
    check("pri_fc",   64'(fail_code), 64'd0);
    check("pri_cyc",  64'(cycle_cnt), 64'd50);

    // ---------------- hang ----------------
    do_reset(1);
    pc = 64'h2C;
    do_start();
    // Cycles 0..3 PC 0x30..0x3C, cycle 4 onward PC held at 0x40; hang hits on cycle 11.
    run_plain(4);
    pc = 64'h40;
    for (int i = 0; i < 7; i++) cyc();
    check("hang_pre_done", 64'(done), 64'd0);
    check("hang_pre_cyc",  64'(cycle_cnt), 64'd11);
    cyc();
    check("hang_done", 64'(done), 64'd1);
    check("hang_pass", 64'(pass), 64'd0);
    check("hang_fc",   64'(fail_code), 64'd2);
    check("hang_cyc",  64'(cycle_cnt), 64'd12);

    // ---------------- near misses and reset mid-run ----------------
    do_reset(1);
    do_start();
    run_plain(3);
    pc = pc + 64'd4; wb_we = 1'b1; wb_addr = 5'd31; wb_data = 64'hACD;
    cyc();
    pc = pc + 64'd4; wb_addr = 5'd30; wb_data = 64'hACE;
    cyc();
    wb_we = 1'b0;
    run_plain(2);
    check("nm_done", 64'(done), 64'd0);
    check("nm_cyc",  64'(cycle_cnt), 64'd7);
    check("nm_wb",   64'(wb_cnt), 64'd2);
    do_reset(1);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_cyc",  64'(cycle_cnt), 64'd0);
    check("mid_rst_wb",   64'(wb_cnt), 64'd0);
    check("mid_rst_fc",   64'(fail_code), 64'd0);
    // Signature while IDLE must not produce a verdict or count.
    pc = pc + 64'd4; wb_we = 1'b1; wb_addr = 5'd31; wb_data = 64'hACE;
    cyc();
    wb_we = 1'b0;
    run_plain(2);
    check("idle_sig_done", 64'(done), 64'd0);
    check("idle_sig_cyc",  64'(cycle_cnt), 64'd0);
    check("idle_sig_wb",   64'(wb_cnt), 64'd0);

    // ---------------- x0 writes ----------------
    do_reset(1);
`ifdef MON_X0_GUARD_EN
    check("x0_rst", 64'(x0_viol), 64'd0);
`endif
    do_start();
    pc = pc + 64'd4; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 64'h0;
    cyc();
`ifdef MON_X0_GUARD_EN
    check("x0_zero", 64'(x0_viol), 64'd0);
`endif
    pc = pc + 64'd4; wb_data = 64'h5;
    cyc();
    wb_we = 1'b0;
`ifdef MON_X0_GUARD_EN
    check("x0_set", 64'(x0_viol), 64'd1);
`endif
    check("x0_wb", 64'(wb_cnt), 64'd0);
    run_plain(2);
`ifdef MON_X0_GUARD_EN
    check("x0_sticky", 64'(x0_viol), 64'd1);
`endif
    pc = pc + 64'd4; wb_we = 1'b1; wb_addr = 5'd31; wb_data = 64'hACE;
    cyc();
    wb_we = 1'b0;
    check("x0_pass", 64'(pass), 64'd1);
    check("x0_fc",   64'(fail_code), 64'd0);
    check("x0_cyc",  64'(cycle_cnt), 64'd5);
`ifdef MON_X0_GUARD_EN
    check("x0_after_pass", 64'(x0_viol), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_run_monitor.md
Name: core_run_monitor

Overview:
- Parametrised, synthesizable run-status monitor attached to the register-file writeback port and the fetch PC of the pipelined RV64I core.
- Replaces bench-only pass/timeout/hang checks with a small state machine that reports a latched verdict:
  - PASS when the signature register receives the signature value.
  - FAIL on cycle-budget timeout.
  - FAIL on a PC hang, where the PC stays unchanged too long.
- Exposes cycle and writeback counters for benches and FPGA debug.

Parameters:
- XLEN, 64, datapath width of wb_data and pc.
- REG_AW, 5, register address width.
- SIG_REG, 31, register index watched for the signature.
- SIG_VALUE, 64'h0000_0000_0000_0ACE, signature that means success.
- TIMEOUT_CYCLES, 1000, run-cycle budget before a timeout fail; must be at least 1.
- HANG_CYCLES, 64, consecutive cycles with unchanged PC that count as a hang; must be at least 2.
- CNT_W, 32, width of cycle_cnt and wb_cnt.

Ports:
- clk, input, 1, core clock; all logic is rising-edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse that arms the monitor (IDLE to RUN).
- wb_we, input, 1, register-file write enable (WE3).
- wb_addr, input, REG_AW, register-file write address (A3).
- wb_data, input, XLEN, register-file write data (WD3).
- pc, input, XLEN, fetch-stage PC (PC_F).
- done, output, 1, verdict latched.
- pass, output, 1, verdict is PASS; valid only when done=1.
- fail_code, output, 2, verdict code: 0=none, 1=timeout, 2=hang, 3=reserved.
- cycle_cnt, output, CNT_W, cycles spent in RUN.
- wb_cnt, output, CNT_W, qualifying writebacks in RUN (wb_we=1 and wb_addr!=0).
- x0_viol, output, 1, sticky flag for a nonzero write to x0; present only with MON_X0_GUARD_EN.

Behaviour:
- Reset: when rst=1 at a clk edge:
  - State goes to IDLE.
  - done, pass, fail_code, cycle_cnt, wb_cnt, x0_viol and the internal hang counter and last-PC register all clear to 0.
  - Reset mid-RUN or in a verdict state behaves identically and discards the verdict.
- IDLE:
  - Outputs hold.
  - start=1 moves to RUN next cycle and clears the counters.
  - last_pc is loaded with pc on the same edge.
- RUN, on each cycle:
  - cycle_cnt increments, saturating at all-ones.
  - wb_cnt increments on each qualifying writeback, saturating.
  - Hang counter: if pc equals last_pc it increments, otherwise it clears and last_pc is loaded with pc.
- RUN exit checks, evaluated every RUN cycle in priority order (highest first):
  - pass_hit: wb_we=1 and wb_addr==SIG_REG and wb_data==SIG_VALUE. Next state is PASS.
  - timeout_hit: cycle_cnt==TIMEOUT_CYCLES-1 before the increment. Next state is FAIL, fail_code=1.
  - hang_hit: the hang counter would reach HANG_CYCLES-1 with pc==last_pc. Next state is FAIL, fail_code=2.
  - If several hit in the same cycle, the highest priority wins; PASS beats both fails.
- Verdict latency:
  - A verdict becomes visible one cycle after its triggering cycle: done=1, plus pass=1 or the fail_code.
  - The triggering cycle is counted in cycle_cnt, and in wb_cnt if it qualifies.
- PASS and FAIL states:
  - Terminal until rst.
  - Counters freeze and start is ignored.
  - done, pass and fail_code hold stable.
- SIG_REG==0: pass_hit can never fire, because x0 is never architecturally written; the timeout or hang check decides the verdict.
- start arriving while in RUN is ignored; no restart.
- Monitor is purely observational and never back-pressures the core.

Optional Feature:
- Macro: MON_X0_GUARD_EN.
- With the macro defined:
  - x0_viol is added.
  - In RUN, wb_we=1, wb_addr==0 and wb_data!=0 sets x0_viol; it stays sticky until rst.
  - A write of zero to x0 (NOP or bubble) does not set it.
  - x0_viol does not affect the verdict.
- Without the macro: the x0_viol port and its logic are absent, and the rest is unchanged.

Test Plan:
- Basic pass:
  - Stimulus: rst for 3 cycles, then start; PC advances by 4 each cycle; at RUN cycle 10 drive wb_we=1, wb_addr=31, wb_data=0xACE.
  - Required: next cycle done=1, pass=1, fail_code=0, cycle_cnt=11, wb_cnt=1; all hold for 20 more cycles.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50; PC keeps changing; no signature.
  - Required: after 50 RUN cycles done=1, pass=0, fail_code=1, cycle_cnt=50.
- Hang:
  - Stimulus: HANG_CYCLES=8; PC held at 0x40 from RUN cycle 5.
  - Required: done=1, fail_code=2 with cycle_cnt=12.
- Same-cycle priority:
  - Stimulus: signature write lands on the same cycle as the timeout hit.
  - Required: pass=1, fail_code=0.
- Reset mid-run and near-miss signatures:
  - Stimulus: rst during RUN at cycle 7.
  - Required: all outputs 0 and state IDLE; a signature write while in IDLE gives done=0.
  - Stimulus: wb_addr=31 with wb_data=0xACD.
  - Required: no pass.
- X0 guard (MON_X0_GUARD_EN):
  - Stimulus: write 0 to x0.
  - Required: x0_viol=0.
  - Stimulus: then write 0x5 to x0.
  - Required: x0_viol=1 and sticky; a later signature still gives pass=1.
